// File: rtl/game_pkg.sv
// game_pkg: shared definitions for the Asteroid Defense round sequencer.
//   - state_t        : round lifecycle state encoding (2 bits)
//   - *_W            : datapath widths for score, level and lives
//   - *_DEF          : default values of the game_sequencer parameters
//   - sat_add_score  : score + level with saturation at a ceiling
package game_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_OVER = 2'd2
  } state_t;

  localparam int SCORE_W = 14;
  localparam int LEVEL_W = 4;
  localparam int LIVES_W = 2;

  localparam int LIVES_INIT_DEF       = 3;
  localparam int FRAMES_PER_LEVEL_DEF = 1800;
  localparam int MAX_LEVEL_DEF        = 9;
  localparam int SCORE_MAX_DEF        = 9999;
  localparam int OVER_HOLD_FRAMES_DEF = 180;

  // The ceiling is at most 9999 and the level at most 15, so the 14-bit
  // sum cannot wrap before the compare clamps it.
  function automatic logic [SCORE_W-1:0] sat_add_score(
    input logic [SCORE_W-1:0] score_v,
    input logic [LEVEL_W-1:0] level_v,
    input logic [SCORE_W-1:0] max_v
  );
    logic [SCORE_W-1:0] sum_v;
    sum_v = score_v + {{(SCORE_W-LEVEL_W){1'b0}}, level_v};
    if (sum_v > max_v) begin
      return max_v;
    end else begin
      return sum_v;
    end
  endfunction

endpackage

// File: rtl/game_sequencer_frame_counter.sv
// frame_counter: mod-N counter advanced by frame ticks.
//   clock, reset : system clock, synchronous active-high reset
//   clear        : synchronous clear, wins over tick
//   tick         : advance by one (already gated by the caller's state)
//   wrap         : high in the cycle whose tick moves the count from N-1 to 0
// wrap is combinational so the parent can act on the rollover tick itself;
// the parent registers everything it exposes.
module frame_counter #(
  parameter int N = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic wrap
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [CW-1:0] count_r;

  // Rollover detect for the current tick
  always_comb begin
    wrap = tick && (count_r == LAST);
  end

  // Count register with clear priority over tick
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count_r <= '0;
    end else if (tick) begin
      if (count_r == LAST) begin
        count_r <= '0;
      end else begin
        count_r <= count_r + CW'(1'b1);
      end
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: Asteroid Defense round lifecycle (IDLE -> PLAY -> OVER).
//   clock, reset : system clock, synchronous active-high reset
//   start        : round-start pulse (accepted only in IDLE)
//   frame_tick   : one pulse per video frame (level timer / game-over hold)
//   hit, breach  : gameplay events (acted on only in PLAY)
//   playing      : high in PLAY, enables the spawner
//   game_over    : high in OVER
//   score        : current or last-round score, saturating at SCORE_MAX
//   lives        : remaining lives
//   level        : current level 1..MAX_LEVEL, 0 before the first round
//   level_up     : one-cycle pulse on a level increment
// All outputs are registered.
module game_sequencer
  import game_pkg::*;
#(
  parameter int LIVES_INIT       = LIVES_INIT_DEF,
  parameter int FRAMES_PER_LEVEL = FRAMES_PER_LEVEL_DEF,
  parameter int MAX_LEVEL        = MAX_LEVEL_DEF,
  parameter int SCORE_MAX        = SCORE_MAX_DEF,
  parameter int OVER_HOLD_FRAMES = OVER_HOLD_FRAMES_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               frame_tick,
  input  logic               hit,
  input  logic               breach,
  output logic               playing,
  output logic               game_over,
  output logic [SCORE_W-1:0] score,
  output logic [LIVES_W-1:0] lives,
  output logic [LEVEL_W-1:0] level,
  output logic               level_up
);

  localparam logic [LIVES_W-1:0] LIVES_INIT_L = LIVES_W'(LIVES_INIT);
  localparam logic [LEVEL_W-1:0] MAX_LEVEL_L  = LEVEL_W'(MAX_LEVEL);
  localparam logic [SCORE_W-1:0] SCORE_MAX_L  = SCORE_W'(SCORE_MAX);

  state_t             state_r, state_nxt_s;
  logic [SCORE_W-1:0] score_r, score_nxt_s;
  logic [LIVES_W-1:0] lives_r, lives_nxt_s;
  logic [LEVEL_W-1:0] level_r, level_nxt_s;
  logic               level_up_r, level_up_nxt_s;
  logic               playing_r, game_over_r;

  logic level_tick_s, level_clr_s, level_wrap_s;
  logic hold_tick_s, hold_clr_s, hold_wrap_s;
  logic last_breach_s;

  // Frame ticks only count in the state that owns each timer
  always_comb begin
    level_tick_s  = frame_tick && (state_r == S_PLAY);
    hold_tick_s   = frame_tick && (state_r == S_OVER);
    last_breach_s = breach && (lives_r == LIVES_W'(1));
    // Level timer restarts every round; hold timer restarts every OVER entry
    level_clr_s   = (state_r != S_PLAY) || (state_nxt_s != S_PLAY);
    hold_clr_s    = (state_r != S_OVER);
  end

  frame_counter #(.N(FRAMES_PER_LEVEL)) u_level_timer (
    .clock (clock),
    .reset (reset),
    .clear (level_clr_s),
    .tick  (level_tick_s),
    .wrap  (level_wrap_s)
  );

  frame_counter #(.N(OVER_HOLD_FRAMES)) u_hold_timer (
    .clock (clock),
    .reset (reset),
    .clear (hold_clr_s),
    .tick  (hold_tick_s),
    .wrap  (hold_wrap_s)
  );

  // Next-state and next-output logic
  always_comb begin
    state_nxt_s    = state_r;
    score_nxt_s    = score_r;
    lives_nxt_s    = lives_r;
    level_nxt_s    = level_r;
    level_up_nxt_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          score_nxt_s = '0;
          lives_nxt_s = LIVES_INIT_L;
          level_nxt_s = LEVEL_W'(1);
          state_nxt_s = S_PLAY;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_PLAY: begin
        if (hit) begin
          score_nxt_s = sat_add_score(score_r, level_r, SCORE_MAX_L);
        end else begin
          score_nxt_s = score_r;
        end
        // A terminal breach takes priority over a coincident level rollover
        if (last_breach_s) begin
          lives_nxt_s = '0;
          state_nxt_s = S_OVER;
        end else if (breach) begin
          lives_nxt_s = lives_r - LIVES_W'(1);
        end else begin
          lives_nxt_s = lives_r;
        end
        if (level_wrap_s && !last_breach_s && (level_r < MAX_LEVEL_L)) begin
          level_nxt_s    = level_r + LEVEL_W'(1);
          level_up_nxt_s = 1'b1;
        end else begin
          level_nxt_s    = level_r;
        end
      end
      S_OVER: begin
        if (hold_wrap_s) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_OVER;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; status flags follow the next state
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= S_IDLE;
      score_r     <= '0;
      lives_r     <= '0;
      level_r     <= '0;
      level_up_r  <= 1'b0;
      playing_r   <= 1'b0;
      game_over_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      score_r     <= score_nxt_s;
      lives_r     <= lives_nxt_s;
      level_r     <= level_nxt_s;
      level_up_r  <= level_up_nxt_s;
      playing_r   <= (state_nxt_s == S_PLAY);
      game_over_r <= (state_nxt_s == S_OVER);
    end
  end

  assign playing   = playing_r;
  assign game_over = game_over_r;
  assign score     = score_r;
  assign lives     = lives_r;
  assign level     = level_r;
  assign level_up  = level_up_r;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed self-checking bench for game_sequencer with short timers
// (4 frames per level, 3 hold frames) and a small score ceiling (20).
module tb_game_sequencer;

  logic        clock;
  logic        reset;
  logic        start;
  logic        frame_tick;
  logic        hit;
  logic        breach;
  logic        playing;
  logic        game_over;
  logic [13:0] score;
  logic [1:0]  lives;
  logic [3:0]  level;
  logic        level_up;

  int checks = 0;
  int errors = 0;

  game_sequencer #(
    .LIVES_INIT       (3),
    .FRAMES_PER_LEVEL (4),
    .MAX_LEVEL        (9),
    .SCORE_MAX        (20),
    .OVER_HOLD_FRAMES (3)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .frame_tick (frame_tick),
    .hit        (hit),
    .breach     (breach),
    .playing    (playing),
    .game_over  (game_over),
    .score      (score),
    .lives      (lives),
    .level      (level),
    .level_up   (level_up)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs {start,tick,hit,breach}, then sample 1 ns after the edge
  task automatic cyc(input logic s, input logic t, input logic h, input logic b);
    start = s; frame_tick = t; hit = h; breach = b;
    @(posedge clock);
    #1;
    start = 1'b0; frame_tick = 1'b0; hit = 1'b0; breach = 1'b0;
  endtask

  task automatic check_all(input string tag, input logic p, input logic g,
                           input int sc, input int li, input int lv, input logic lu);
    check({tag, ".playing"},   16'(p),  16'(p));
    check({tag, ".playing"},   16'(playing),   16'(p));
    check({tag, ".game_over"}, 16'(game_over), 16'(g));
    check({tag, ".score"},     16'(score),     16'(sc));
    check({tag, ".lives"},     16'(lives),     16'(li));
    check({tag, ".level"},     16'(level),     16'(lv));
    check({tag, ".level_up"},  16'(level_up),  16'(lu));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; frame_tick = 1'b0; hit = 1'b0; breach = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    check_all("reset", 1'b0, 1'b0, 0, 0, 0, 1'b0);
    reset = 1'b0;
    cyc(0, 1, 1, 1);
    check_all("idle_ignores_events", 1'b0, 1'b0, 0, 0, 0, 1'b0);

    // Round 1
    cyc(1, 0, 0, 0);
    check_all("start", 1'b1, 1'b0, 0, 3, 1, 1'b0);
    cyc(0, 0, 1, 0); check("hit1.score", 16'(score), 16'd1);
    cyc(0, 0, 1, 0); cyc(0, 0, 1, 0);
    check("hit3.score", 16'(score), 16'd3);
    cyc(0, 1, 0, 0); cyc(0, 1, 0, 0); cyc(0, 1, 0, 0);
    check("tick3.level", 16'(level), 16'd1);
    check("tick3.level_up", 16'(level_up), 16'd0);
    cyc(0, 1, 0, 0);
    check("rollover.level", 16'(level), 16'd2);
    check("rollover.level_up", 16'(level_up), 16'd1);
    cyc(0, 0, 1, 0);
    check("level_up_drop", 16'(level_up), 16'd0);
    check("hit_lvl2.score", 16'(score), 16'd5);
    cyc(0, 0, 0, 1); check("breach1.lives", 16'(lives), 16'd2);
    cyc(1, 0, 0, 1); check("breach2_start_ignored.lives", 16'(lives), 16'd1);
    check("breach2.playing", 16'(playing), 16'd1);
    cyc(0, 0, 0, 1);
    check_all("last_breach", 1'b0, 1'b1, 5, 0, 2, 1'b0);
    cyc(0, 0, 1, 0); check("over_hit.score", 16'(score), 16'd5);
    cyc(1, 0, 0, 0); check("over_start.game_over", 16'(game_over), 16'd1);
    check("over_start.playing", 16'(playing), 16'd0);
    cyc(0, 1, 0, 0); cyc(0, 1, 0, 1);
    check("hold2.game_over", 16'(game_over), 16'd1);
    cyc(1, 1, 0, 0);
    check_all("hold_done_start_ignored", 1'b0, 1'b0, 5, 0, 2, 1'b0);

    // Round 2: climb to the level ceiling and saturate the score
    cyc(1, 0, 0, 0);
    check_all("restart", 1'b1, 1'b0, 0, 3, 1, 1'b0);
    for (int i = 0; i < 32; i++) cyc(0, 1, 0, 0);
    check("climb.level", 16'(level), 16'd9);
    cyc(0, 0, 1, 0); check("sat1.score", 16'(score), 16'd9);
    cyc(0, 0, 1, 0); check("sat2.score", 16'(score), 16'd18);
    cyc(0, 0, 1, 0); check("sat3.score", 16'(score), 16'd20);
    cyc(0, 0, 1, 0); check("sat4.score", 16'(score), 16'd20);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 0, 0);
      check("max_level.level_up", 16'(level_up), 16'd0);
    end
    check("max_level.level", 16'(level), 16'd9);
    cyc(0, 0, 0, 1); cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
    check("round2_over.game_over", 16'(game_over), 16'd1);
    cyc(0, 1, 0, 0); cyc(0, 1, 0, 0); cyc(0, 1, 0, 0);
    check("round2_idle.game_over", 16'(game_over), 16'd0);

    // Round 3: terminal breach with hit on a rollover tick
    cyc(1, 0, 0, 0);
    check_all("round3_start", 1'b1, 1'b0, 0, 3, 1, 1'b0);
    cyc(0, 1, 0, 0); cyc(0, 1, 0, 1); cyc(0, 1, 0, 1);
    check("round3_pre.lives", 16'(lives), 16'd1);
    cyc(0, 1, 1, 1);
    check_all("breach_on_rollover", 1'b0, 1'b1, 1, 0, 1, 1'b0);
    cyc(0, 1, 0, 0); cyc(0, 1, 0, 0); cyc(0, 1, 0, 0);
    check("round3_idle.game_over", 16'(game_over), 16'd0);

    // Round 4: reset mid-play overrides concurrent events
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 1);
    check_all("round4_mid", 1'b1, 1'b0, 2, 2, 2, 1'b0);
    reset = 1'b1;
    cyc(1, 1, 1, 1);
    check_all("mid_reset", 1'b0, 1'b0, 0, 0, 0, 1'b0);
    reset = 1'b0;
    cyc(1, 0, 0, 0);
    check_all("post_reset_start", 1'b1, 1'b0, 0, 3, 1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
